// File: rtl/fm_voice_engine.sv
// Time-multiplexed FM voice engine: NUM_CHANNELS voices x NUM_OPS operators,
// one shared external cosine LUT, one mixed sample per frame.
module fm_voice_engine #(
  parameter int NUM_CHANNELS = 8,
  parameter int NUM_OPS      = 4,
  parameter int NUM_BITS     = 32,
  parameter int WIDTH        = 18,
  parameter int ADDR_BITS    = 15,
  parameter int LUT_LATENCY  = 2,
  parameter int OUT_BITS     = WIDTH + $clog2(NUM_CHANNELS * NUM_OPS)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     frame_start,
  input  logic [NUM_CHANNELS-1:0]                  gate_in,
  input  logic [NUM_CHANNELS*NUM_OPS*NUM_BITS-1:0] tuning_in,
  input  logic                                     algorithm,
  input  logic [7:0]                               mod_depth,
  input  logic [2:0]                               feedback,
  output logic                                     lut_rd,
  output logic [ADDR_BITS-1:0]                     lut_addr,
  input  logic [WIDTH-1:0]                         lut_data,
  output logic [OUT_BITS-1:0]                      mix_out,
  output logic                                     mix_valid,
  output logic                                     busy
);

  localparam int NUM_SLOTS = NUM_CHANNELS * NUM_OPS;
  localparam int CW        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int KW        = $clog2(NUM_OPS);
  localparam int IW        = $clog2(NUM_SLOTS);
  localparam int WCW       = $clog2(LUT_LATENCY + 1);
  localparam int MOD_SHIFT = NUM_BITS - WIDTH - 8;

  localparam logic [WCW-1:0] WAIT_LAST = WCW'((LUT_LATENCY >= 2) ? LUT_LATENCY - 2 : 0);
  localparam logic [KW-1:0]  K_LAST    = KW'(NUM_OPS - 1);
  localparam logic [CW-1:0]  C_LAST    = CW'(NUM_CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [NUM_BITS-1:0]     phase    [NUM_SLOTS];
  logic signed [WIDTH-1:0] fb_reg   [NUM_CHANNELS];
  logic [NUM_BITS-1:0]     tuning_w [NUM_SLOTS];

  logic signed [WIDTH-1:0] prev_out;
  logic [OUT_BITS-1:0]     acc;
  logic [CW-1:0]           c;
  logic [KW-1:0]           k;
  logic [IW-1:0]           idx;
  logic [WCW-1:0]          wait_cnt;

  logic                    alg_l;
  logic [7:0]              depth_l;
  logic [2:0]              fb_l;
  logic [NUM_CHANNELS-1:0] gate_l;

  logic [NUM_BITS-1:0]     fb_off;
  logic [NUM_BITS-1:0]     mod_off;
  logic [NUM_BITS-1:0]     offset;
  logic signed [WIDTH+8:0] prod;
  logic [OUT_BITS-1:0]     contrib;
  logic [OUT_BITS-1:0]     acc_next;
  logic                    last_op;
  logic                    wait_done;

  // Slice the flat tuning bus into one word per (channel, operator) slot
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_tune
    assign tuning_w[gi] = tuning_in[gi*NUM_BITS +: NUM_BITS];
  end

  // Phase offset for the current operator and the sample's mix contribution
  always_comb begin
    fb_off   = NUM_BITS'(fb_reg[c]) << (MOD_SHIFT + int'(fb_l));
    prod     = (WIDTH+9)'(prev_out) * (WIDTH+9)'($signed({1'b0, depth_l}));
    mod_off  = NUM_BITS'(prod) << MOD_SHIFT;
    offset   = '0;
    if (k == '0) begin
      if (fb_l != '0) offset = fb_off;
    end else if (!alg_l) begin
      offset = mod_off;
    end
    contrib  = '0;
    if (gate_l[c] && (alg_l || (k == K_LAST))) contrib = OUT_BITS'($signed(lut_data));
    acc_next = acc + contrib;
    last_op   = (k == K_LAST) && (c == C_LAST);
    wait_done = (wait_cnt == WAIT_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    lut_rd    = 1'b0;
    lut_addr  = '0;
    mix_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        lut_rd   = 1'b1;
        lut_addr = ADDR_BITS'((phase[idx] + offset) >> (NUM_BITS - ADDR_BITS));
        busy     = 1'b1;
        state_d  = (LUT_LATENCY == 1) ? S_ACCUM : S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_done) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        busy    = 1'b1;
        state_d = last_op ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        mix_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: frame latching, phase stepping, feedback capture and mixing.
  // mix_out is loaded with the final sum on the last ACCUM edge so that it is
  // already stable during the DONE cycle when mix_valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++)    phase[IW'(i)]  <= '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) fb_reg[CW'(i)] <= '0;
      prev_out <= '0;
      acc      <= '0;
      mix_out  <= '0;
      c        <= '0;
      k        <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      alg_l    <= 1'b0;
      depth_l  <= '0;
      fb_l     <= '0;
      gate_l   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            alg_l   <= algorithm;
            depth_l <= mod_depth;
            fb_l    <= feedback;
            gate_l  <= gate_in;
            acc     <= '0;
            c       <= '0;
            k       <= '0;
            idx     <= '0;
          end
        end
        S_ISSUE: begin
          if (gate_l[c]) begin
            phase[idx] <= phase[idx] + tuning_w[idx];
          end else begin
            phase[idx] <= '0;
            fb_reg[c]  <= '0;
          end
          wait_cnt <= '0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + WCW'(1);
        end
        S_ACCUM: begin
          prev_out <= lut_data;
          if (k == '0) fb_reg[c] <= gate_l[c] ? $signed(lut_data) : '0;
          acc <= acc_next;
          if (last_op) mix_out <= acc_next;
          idx <= idx + IW'(1);
          if (k == K_LAST) begin
            k <= '0;
            c <= c + CW'(1);
          end else begin
            k <= k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_voice_engine.sv
// Self-checking bench for fm_voice_engine (2 voices x 2 operators, LUT latency 2).
module tb_fm_voice_engine;

  localparam int NC = 2;
  localparam int NK = 2;
  localparam int NS = NC * NK;
  localparam int OB = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic           frame_start;
  logic [NC-1:0]  gate_in;
  logic [NS*32-1:0] tuning_in;
  logic           algorithm;
  logic [7:0]     mod_depth;
  logic [2:0]     feedback;
  logic           lut_rd;
  logic [14:0]    lut_addr;
  logic [17:0]    lut_data;
  logic [OB-1:0]  mix_out;
  logic           mix_valid;
  logic           busy;

  int nvec = 0;
  int nmis = 0;
  int lut_mode = 0;

  // Reference state: per-slot phases, per-voice feedback sample, expectations
  logic [31:0] tun   [NS];
  logic [31:0] ph_m  [NS];
  int          fb_m  [NC];
  logic [14:0] exp_addr [NS];
  int          exp_mix;

  logic signed [17:0] pipe0 = '0;
  logic signed [17:0] pipe1 = '0;

  fm_voice_engine #(
    .NUM_CHANNELS(NC),
    .NUM_OPS(NK),
    .LUT_LATENCY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .gate_in(gate_in),
    .tuning_in(tuning_in),
    .algorithm(algorithm),
    .mod_depth(mod_depth),
    .feedback(feedback),
    .lut_rd(lut_rd),
    .lut_addr(lut_addr),
    .lut_data(lut_data),
    .mix_out(mix_out),
    .mix_valid(mix_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign tuning_in = {tun[3], tun[2], tun[1], tun[0]};

  // LUT contents: 0 = identity, 1 = constant 256, 2 = scrambled signed values
  function automatic logic signed [17:0] lut_fn(input logic [14:0] ad);
    logic [31:0] t;
    case (lut_mode)
      0:       return {3'b000, ad};
      1:       return 18'sd256;
      default: begin
        t = {17'b0, ad} * 32'd40503 + 32'd12345;
        return t[17:0] ^ t[31:14];
      end
    endcase
  endfunction

  // Two-cycle LUT read pipeline
  always @(posedge clk) begin
    pipe0 <= lut_rd ? lut_fn(lut_addr) : 18'sd0;
    pipe1 <= pipe0;
  end
  assign lut_data = pipe1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) ph_m[i] = '0;
    for (int c = 0; c < NC; c++) fb_m[c] = 0;
  endtask

  // One frame of the engine described with plain integer arithmetic
  task automatic model_frame(input logic [1:0] g, input logic a, input logic [7:0] d,
                             input logic [2:0] f);
    int prev;
    int s;
    int i;
    longint off;
    logic [31:0] sum;
    exp_mix = 0;
    prev = 0;
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < NK; k++) begin
        i = c * NK + k;
        if (g[c]) begin
          if (k == 0) off = (f == 0) ? 64'sd0 : longint'(fb_m[c]) * (longint'(1) << (6 + int'(f)));
          else        off = a ? 64'sd0 : longint'(prev) * longint'(d) * 64;
          sum = ph_m[i] + off[31:0];
          exp_addr[i] = sum[31:17];
          s = int'(lut_fn(exp_addr[i]));
          ph_m[i] = ph_m[i] + tun[i];
          if (k == 0) fb_m[c] = s;
          if (a || k == NK - 1) exp_mix += s;
          prev = s;
        end else begin
          ph_m[i] = '0;
          fb_m[c] = 0;
        end
      end
    end
  endtask

  // glitch: 0 none, 1 extra frame_start mid-frame, 2 inputs change mid-frame,
  // 3 reset asserted at cycle 5
  task automatic run_frame(input logic [1:0] g, input logic a, input logic [7:0] d,
                           input logic [2:0] f, input int glitch);
    logic [14:0] rd_addr [NS];
    logic [OB-1:0] em;
    int nrd, vcyc, cyc;
    logic noisy;
    for (int i = 0; i < NS; i++) rd_addr[i] = '0;
    if (glitch != 3) model_frame(g, a, d, f);
    em = exp_mix[OB-1:0];
    @(negedge clk);
    gate_in = g; algorithm = a; mod_depth = d; feedback = f; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("busy_rise", 64'(busy), 64'd1);
    nrd = 0; vcyc = 0; cyc = 1;
    while (vcyc == 0 && cyc <= 40) begin
      if (lut_rd) begin
        if (nrd < NS) rd_addr[nrd] = lut_addr;
        nrd++;
      end
      if (mix_valid) begin
        vcyc = cyc;
        check("busy_at_valid", 64'(busy), 64'd0);
        check("mix_out", 64'(mix_out), 64'(em));
      end
      if (glitch == 1) frame_start = (cyc == 5);
      if (glitch == 2 && cyc == 3) begin
        gate_in = ~g; algorithm = ~a; mod_depth = ~d; feedback = ~f;
      end
      if (glitch == 3 && cyc == 5) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      if (vcyc == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (glitch == 3) begin
      noisy = 1'b0;
      for (int n = 0; n < 20; n++) begin
        if (mix_valid || busy || lut_rd) noisy = 1'b1;
        @(negedge clk);
      end
      check("abort_quiet", 64'(noisy), 64'd0);
      check("abort_mix_out", 64'(mix_out), 64'd0);
      model_reset();
      return;
    end
    check("frame_len", 64'(vcyc), 64'd13);
    check("lut_rd_count", 64'(nrd), 64'(NS));
    for (int i = 0; i < NS; i++)
      if (g[i / NK]) check($sformatf("lut_addr[%0d]", i), 64'(rd_addr[i]), 64'(exp_addr[i]));
    @(negedge clk);
    check("valid_pulse", 64'(mix_valid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; gate_in = '0; algorithm = 1'b0;
    mod_depth = '0; feedback = '0;
    for (int i = 0; i < NS; i++) tun[i] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_lut_rd", 64'(lut_rd), 64'd0);
    check("rst_lut_addr", 64'(lut_addr), 64'd0);
    check("rst_mix_out", 64'(mix_out), 64'd0);
    check("rst_mix_valid", 64'(mix_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Phase stepping on voice 0, operator 0, then wrap through 2^32
    lut_mode = 0;
    tun[0] = 32'h0010_0000;
    repeat (3) run_frame(2'b01, 1'b1, 8'd0, 3'd0, 0);
    tun[0] = 32'hFFC0_0000;
    run_frame(2'b01, 1'b1, 8'd0, 3'd0, 0);
    tun[0] = 32'h0020_0000;
    run_frame(2'b01, 1'b1, 8'd0, 3'd0, 0);
    run_frame(2'b01, 1'b1, 8'd0, 3'd0, 0);

    // Stack modulation with a constant LUT
    lut_mode = 1;
    tun[0] = 32'h0123_4567; tun[1] = 32'h0040_0000;
    tun[2] = 32'h0765_4321; tun[3] = 32'h0080_0000;
    run_frame(2'b11, 1'b0, 8'd0, 3'd0, 0);
    run_frame(2'b11, 1'b0, 8'd4, 3'd0, 0);
    run_frame(2'b11, 1'b0, 8'd4, 3'd0, 0);

    // Parallel sum, then all voices gated off
    run_frame(2'b11, 1'b1, 8'd0, 3'd0, 0);
    run_frame(2'b00, 1'b1, 8'd0, 3'd0, 0);

    // Operator-0 feedback on, then off
    run_frame(2'b11, 1'b1, 8'd0, 3'd1, 0);
    run_frame(2'b11, 1'b1, 8'd0, 3'd1, 0);
    run_frame(2'b11, 1'b1, 8'd0, 3'd0, 0);

    // Robustness: ignored strobe, latched inputs, reset mid-frame
    lut_mode = 2;
    run_frame(2'b11, 1'b0, 8'd9, 3'd2, 1);
    run_frame(2'b10, 1'b0, 8'd77, 3'd3, 2);
    run_frame(2'b11, 1'b0, 8'd9, 3'd2, 3);
    run_frame(2'b11, 1'b0, 8'd9, 3'd2, 0);

    // Randomised frames against the reference model
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NS; i++) tun[i] = $urandom;
      run_frame(2'($urandom), 1'($urandom), 8'($urandom), 3'($urandom), (n % 5 == 4) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
